dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
Load/store sequencer between the execute stage and the data-memory port. It accepts one memory instruction at a time and formats store data and byte-write-enables. It performs a valid/ready request handshake and waits for the read response. It then hands the raw 32-bit word, addr[1:0] and func3 to the downstream load-mask stage, and holds a pipeline stall until the access completes.

Parameters:
WIDTH, 32, data width; only 32 is supported.
ADDR_WIDTH, 32, byte-address width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  execute stage presents a load/store.
req_we  in  1  1 = store, 0 = load.
req_func3  in  3  RISC-V funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  WIDTH  rs2 store data.
stall  out  1  freeze the upstream pipeline.
misalign_err  out  1  illegal or misaligned request; pulses the same cycle.
mem_req_valid  out  1  memory request.
mem_req_ready  in  1  memory accepts the request.
mem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are 0.
mem_wdata  out  WIDTH  lane-replicated store data.
mem_wbe  out  4  byte write enables; 0 for loads.
mem_resp_valid  in  1  read data valid.
mem_resp_data  in  WIDTH  read word.
ld_valid  out  1  single-cycle load completion.
ld_data  out  WIDTH  raw word for the load-mask stage.
ld_addr_lo  out  2  captured addr[1:0].
ld_func3  out  3  captured func3.
st_done  out  1  single-cycle store completion.

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. Every output and every captured register is 0.
- States: IDLE, ISSUE, WAIT, DONE; one-hot or binary encoding.
- Legality check (IDLE only):
  - Illegal if: func3 is 3, 6 or 7 (load); func3 ≥ 3 (store); addr[0]=1 for halfword; addr[1:0]≠0 for word.
  - Illegal request: misalign_err=1 combinationally, no state change, no memory access, stall=0.
- IDLE to ISSUE: on a legal req_valid, capture addr, func3, we and formatted wdata/wbe.
- ISSUE:
  - mem_req_valid=1, driven from the captured registers.
  - Outputs are held stable until mem_req_ready.
  - On mem_req_ready: a store goes to DONE; a load goes to WAIT.
  - mem_resp_valid arriving in ISSUE is ignored.
- WAIT: on mem_resp_valid, capture mem_resp_data into ld_data and go to DONE.
- DONE:
  - Load: ld_valid=1. Store: st_done=1.
  - ld_data, ld_addr_lo and ld_func3 are held from capture until the next load capture.
  - DONE goes to IDLE unconditionally.
  - req_valid is ignored in DONE, because it still shows the completing instruction.
- stall = (IDLE & req_valid & legal) | ISSUE | WAIT. stall is 0 in DONE, so the pipeline advances at the end of DONE.
- Minimum latency (ready and response immediate): load accepted at cycle 0 → ld_valid at cycle 3; store accepted at cycle 0 → st_done at cycle 2.
- Store formatting:
  - SB: wdata[7:0] replicated ×4, wbe = 4'b0001 << addr[1:0].
  - SH: wdata[15:0] replicated ×2, wbe = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata unchanged, wbe = 4'b1111.
- mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Reset mid-operation: the transaction is abandoned. A mem_resp_valid arriving after reset is ignored, because IDLE ignores responses.
- Address arithmetic does not wrap or carry; bits above [1:0] pass through.

Decomposition:
- Shared header lsu_defs.vh holds the func3 encodings (LB…LHU, SB/SH/SW) and the state encodings. The load-mask stage includes the same header.
- One combinational sub-module, store_align (inputs: func3, addr[1:0], wdata; outputs: mem_wdata, mem_wbe). It also produces the legality bit.

Test Plan:
- LW at 0x0000_1004; ready and response immediate, resp=0xDEADBEEF → ld_valid at cycle 3, ld_data=0xDEADBEEF, ld_addr_lo=0, ld_func3=2; stall high for cycles 0–2.
- SB at 0x0000_2003, wdata=0x0000_00A5 → mem_wdata=0xA5A5A5A5, mem_wbe=4'b1000, mem_addr=0x0000_2000; st_done at cycle 2.
- SH at 0x10 with mem_req_ready low for 3 cycles → mem_req_valid, mem_addr, mem_wdata and mem_wbe stable all 3 cycles; stall held; st_done 1 cycle after ready.
- LH at 0x0000_0011 → misalign_err=1, stall=0, mem_req_valid stays 0, state stays IDLE.
- LBU at 0x22 with the response delayed 4 cycles → stall high throughout; ld_valid=1 for exactly one cycle; req_valid held during DONE does not start a second access.
- Reset asserted in WAIT, then a response arrives post-reset → all outputs 0 immediately; the late response produces no ld_valid.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store path.
// The load-mask stage imports the same func3 encodings.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Data-memory port: request handshake plus read response.
interface dmem_lsu_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [3:0]            mem_wbe;
  logic                  mem_resp_valid;
  logic [WIDTH-1:0]      mem_resp_data;

  modport master (
    output mem_req_valid, mem_addr, mem_wdata, mem_wbe,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wdata, mem_wbe,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/dmem_lsu_store_align.sv
// Store lane replication, byte enables and request legality check.
module store_align
  import dmem_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             we,
  input  logic [2:0]       func3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wbe,
  output logic             legal
);

  always_comb begin
    mem_wdata = wdata;
    mem_wbe   = '0;
    legal     = 1'b0;
    case (func3)
      F3_B, F3_BU: begin
        legal     = !we || (func3 == F3_B);
        mem_wdata = {4{wdata[7:0]}};
        mem_wbe   = 4'b0001 << addr_lo;
      end
      F3_H, F3_HU: begin
        legal     = (!we || (func3 == F3_H)) && !addr_lo[0];
        mem_wdata = {2{wdata[15:0]}};
        mem_wbe   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        legal   = (addr_lo == 2'b00);
        mem_wbe = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
    // Loads share the formatter but must never write.
    if (!we) mem_wbe = '0;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer: one access at a time, issue, wait for read data,
// then hand the raw word to the load-mask stage.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_func3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  stall,
  output logic                  misalign_err,
  dmem_lsu_if.master            mem,
  output logic                  ld_valid,
  output logic [WIDTH-1:0]      ld_data,
  output logic [1:0]            ld_addr_lo,
  output logic [2:0]            ld_func3,
  output logic                  st_done
);

  lsu_state_e            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            func3_q;
  logic                  we_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [3:0]            wbe_q;
  logic [WIDTH-1:0]      ld_data_q;
  logic [1:0]            ld_addr_lo_q;
  logic [2:0]            ld_func3_q;

  logic [WIDTH-1:0]      fmt_wdata;
  logic [3:0]            fmt_wbe;
  logic                  legal;
  logic                  in_idle;

  store_align #(.WIDTH(WIDTH)) u_store_align (
    .we        (req_we),
    .func3     (req_func3),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .mem_wdata (fmt_wdata),
    .mem_wbe   (fmt_wbe),
    .legal     (legal)
  );

  assign in_idle      = (state == ST_IDLE);
  assign misalign_err = in_idle && req_valid && !legal;
  assign stall        = (in_idle && req_valid && legal)
                      || (state == ST_ISSUE) || (state == ST_WAIT);

  assign mem.mem_req_valid = (state == ST_ISSUE);
  assign mem.mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_wbe       = wbe_q;

  assign ld_valid   = (state == ST_DONE) && !we_q;
  assign st_done    = (state == ST_DONE) && we_q;
  assign ld_data    = ld_data_q;
  assign ld_addr_lo = ld_addr_lo_q;
  assign ld_func3   = ld_func3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      func3_q      <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wbe_q        <= '0;
      ld_data_q    <= '0;
      ld_addr_lo_q <= '0;
      ld_func3_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && legal) begin
            state   <= ST_ISSUE;
            addr_q  <= req_addr;
            func3_q <= req_func3;
            we_q    <= req_we;
            wdata_q <= fmt_wdata;
            wbe_q   <= fmt_wbe;
          end
        end
        ST_ISSUE: begin
          if (mem.mem_req_ready) state <= we_q ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          // Load-side outputs change only here, so stores leave them intact.
          if (mem.mem_resp_valid) begin
            ld_data_q    <= mem.mem_resp_data;
            ld_addr_lo_q <= addr_q[1:0];
            ld_func3_q   <= func3_q;
            state        <= ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: loads, stores, back-pressure, illegal
// requests and reset in the middle of a load.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        misalign_err;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [1:0]  ld_addr_lo;
  logic [2:0]  ld_func3;
  logic        st_done;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  dmem_lsu_if bus ();

  dmem_lsu #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_func3    (req_func3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .misalign_err (misalign_err),
    .mem          (bus),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_addr_lo   (ld_addr_lo),
    .ld_func3     (ld_func3),
    .st_done      (st_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    rst = 1'b0;
    set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_mreq", bus.mem_req_valid, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_wbe", bus.mem_wbe, 0);
    chk("rst_ldv", ld_valid, 0);
    chk("rst_std", st_done, 0);
    chk("rst_lddata", ld_data, 0);
    #1 rst = 1'b1;

    // LW at 0x1004, ready and response immediate.
    tick;
    set_req(1'b1, 1'b0, 3'd2, 32'h0000_1004, 32'h0);
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hDEAD_BEEF;
    #1;
    chk("lw_c0_stall", stall, 1);
    chk("lw_c0_mis", misalign_err, 0);
    chk("lw_c0_mreq", bus.mem_req_valid, 0);
    tick;
    chk("lw_c1_mreq", bus.mem_req_valid, 1);
    chk("lw_c1_maddr", bus.mem_addr, 32'h0000_1004);
    chk("lw_c1_wbe", bus.mem_wbe, 0);
    chk("lw_c1_stall", stall, 1);
    tick;
    chk("lw_c2_stall", stall, 1);
    chk("lw_c2_mreq", bus.mem_req_valid, 0);
    chk("lw_c2_ldv", ld_valid, 0);
    tick;
    chk("lw_c3_ldv", ld_valid, 1);
    chk("lw_c3_data", ld_data, 32'hDEAD_BEEF);
    chk("lw_c3_lo", ld_addr_lo, 0);
    chk("lw_c3_f3", ld_func3, 2);
    chk("lw_c3_stall", stall, 0);
    req_valid          = 1'b0;
    bus.mem_resp_valid = 1'b0;
    tick;
    chk("lw_c4_ldv", ld_valid, 0);
    chk("lw_c4_hold", ld_data, 32'hDEAD_BEEF);

    // SB at 0x2003.
    set_req(1'b1, 1'b1, 3'd0, 32'h0000_2003, 32'h0000_00A5);
    #1;
    chk("sb_c0_stall", stall, 1);
    tick;
    chk("sb_c1_mreq", bus.mem_req_valid, 1);
    chk("sb_c1_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    chk("sb_c1_wbe", bus.mem_wbe, 32'h8);
    chk("sb_c1_maddr", bus.mem_addr, 32'h0000_2000);
    tick;
    chk("sb_c2_std", st_done, 1);
    chk("sb_c2_ldv", ld_valid, 0);
    chk("sb_c2_stall", stall, 0);
    chk("sb_c2_ldhold", ld_data, 32'hDEAD_BEEF);
    req_valid = 1'b0;
    tick;
    chk("sb_c3_std", st_done, 0);

    // SH at 0x10 with ready withheld for 3 cycles.
    bus.mem_req_ready = 1'b0;
    set_req(1'b1, 1'b1, 3'd1, 32'h0000_0010, 32'h1234_BEEF);
    tick;
    req_wdata = 32'hFFFF_FFFF;
    req_addr  = 32'h0000_0007;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_wait_mreq", bus.mem_req_valid, 1);
      chk("sh_wait_maddr", bus.mem_addr, 32'h0000_0010);
      chk("sh_wait_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
      chk("sh_wait_wbe", bus.mem_wbe, 32'h3);
      chk("sh_wait_stall", stall, 1);
      chk("sh_wait_std", st_done, 0);
      tick;
    end
    bus.mem_req_ready = 1'b1;
    #1;
    chk("sh_rdy_mreq", bus.mem_req_valid, 1);
    tick;
    chk("sh_done_std", st_done, 1);
    chk("sh_done_stall", stall, 0);
    req_valid = 1'b0;
    tick;
    chk("sh_idle_std", st_done, 0);

    // LH at 0x11: misaligned, rejected in IDLE.
    set_req(1'b1, 1'b0, 3'd1, 32'h0000_0011, 32'h0);
    #1;
    chk("lh_mis", misalign_err, 1);
    chk("lh_stall", stall, 0);
    chk("lh_mreq", bus.mem_req_valid, 0);
    tick;
    chk("lh_mis_next", misalign_err, 1);
    chk("lh_mreq_next", bus.mem_req_valid, 0);
    chk("lh_stall_next", stall, 0);
    // SH with func3 4 is not a store encoding.
    set_req(1'b1, 1'b1, 3'd4, 32'h0000_0020, 32'h0);
    #1;
    chk("st_f3_4_mis", misalign_err, 1);
    req_valid = 1'b0;
    #1;
    chk("lh_mis_drop", misalign_err, 0);

    // LBU at 0x22, response 4 cycles after issue completes.
    tick;
    set_req(1'b1, 1'b0, 3'd4, 32'h0000_0022, 32'h0);
    bus.mem_resp_valid = 1'b0;
    tick;
    chk("lbu_issue_mreq", bus.mem_req_valid, 1);
    chk("lbu_issue_wbe", bus.mem_wbe, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lbu_wait_stall", stall, 1);
      chk("lbu_wait_ldv", ld_valid, 0);
      tick;
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1122_3344;
    tick;
    bus.mem_resp_valid = 1'b0;
    chk("lbu_done_ldv", ld_valid, 1);
    chk("lbu_done_data", ld_data, 32'h1122_3344);
    chk("lbu_done_lo", ld_addr_lo, 2);
    chk("lbu_done_f3", ld_func3, 4);
    chk("lbu_done_mreq", bus.mem_req_valid, 0);
    tick;
    chk("lbu_after_ldv", ld_valid, 0);
    chk("lbu_after_mreq", bus.mem_req_valid, 0);
    req_valid = 1'b0;
    tick;

    // LW at 0x40, reset while waiting for the response.
    set_req(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0);
    bus.mem_resp_valid = 1'b0;
    tick;
    tick;
    chk("rw_wait_stall", stall, 1);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rw_rst_stall", stall, 0);
    chk("rw_rst_mreq", bus.mem_req_valid, 0);
    chk("rw_rst_maddr", bus.mem_addr, 0);
    chk("rw_rst_data", ld_data, 0);
    chk("rw_rst_lo", ld_addr_lo, 0);
    chk("rw_rst_f3", ld_func3, 0);
    #1 rst = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hCAFE_F00D;
    tick;
    chk("rw_late_ldv", ld_valid, 0);
    tick;
    chk("rw_late_ldv2", ld_valid, 0);
    chk("rw_late_data", ld_data, 0);
    chk("rw_late_stall", stall, 0);
    bus.mem_resp_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
